mem_banked: RTL and testbench

Parametrised successor to the single-cycle byte memory. Word-organised, byte-addressable data memory with independent read and write ports, each using a ready/valid handshake. Reads support sizes and sign extension. Accesses that cross a word boundary are split by a per-port two-beat state machine. Out-of-range accesses are flagged, not wrapped. It is the data memory behind the load/store unit.

---
 rtl/mem_banked.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_banked.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_banked.sv
// Byte-addressable word memory with independent ready/valid read and write ports.
// Latency: reads 1 cycle (2 when crossing a word boundary); writes commit at acceptance (+1 for the crossing remainder).
// Backpressure: each port drops ready for one cycle while it finishes the second beat of a crossing access.
module mem_banked #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_adrs,
    input  logic [1:0]          rd_size,
    input  logic                rd_signed,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_adrs,
    input  logic [DATA_W/8-1:0] wr_byt_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic                wr_err
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int IDX_W  = MEM_AW - OFF_W;
    localparam int NWORDS = DEPTH / NB;

    // Largest legal size code: a read may never exceed one word.
    localparam logic [1:0]        SZ_MAX  = 2'(OFF_W);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [4:0]        NB_L    = 5'(NB);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } st_e;

    // Storage is kept packed so the whole array clears in one reset assignment.
    logic [NWORDS-1:0][DATA_W-1:0] mem_q;

    // Zero- or sign-extend the low 2^size bytes of raw up to a full word.
    function automatic logic [DATA_W-1:0] extend(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] res;
        logic [3:0]        nbytes;
        logic              fill;
        nbytes = 4'd1 << size;
        fill   = 1'b0;
        res    = '0;
        for (int b = 0; b < NB; b++) begin
            if (sgn && (b == int'(nbytes) - 1)) begin
                fill = raw[8*b+7];
            end
        end
        for (int b = 0; b < NB; b++) begin
            res[8*b +: 8] = (b < int'(nbytes)) ? raw[8*b +: 8] : {8{fill}};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    st_e               rd_st_q, rd_st_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] rd_low_q, rd_low_d;       // low part of a crossing read, already right-aligned
    logic [IDX_W-1:0]  rd_nidx_q, rd_nidx_d;     // word holding the high part
    logic [OFF_W:0]    rd_lob_q, rd_lob_d;       // number of bytes taken from the low word
    logic [1:0]        rd_size_q, rd_size_d;
    logic              rd_sgn_q, rd_sgn_d;

    logic [3:0]        rd_nb;
    logic [OFF_W-1:0]  rd_off;
    logic [IDX_W-1:0]  rd_idx;
    logic [ADDR_W:0]   rd_end;
    logic [4:0]        rd_tail;
    logic              rd_illegal;
    logic              rd_cross;
    logic [DATA_W-1:0] rd_shift;

    assign rd_nb      = 4'd1 << rd_size;
    assign rd_off     = rd_adrs[OFF_W-1:0];
    assign rd_idx     = rd_adrs[MEM_AW-1:OFF_W];
    assign rd_end     = {1'b0, rd_adrs} + {{(ADDR_W-3){1'b0}}, rd_nb};
    assign rd_tail    = 5'(rd_off) + {1'b0, rd_nb};
    assign rd_illegal = (rd_size > SZ_MAX) || (rd_end > DEPTH_L);
    assign rd_cross   = rd_tail > NB_L;
    assign rd_shift   = mem_q[rd_idx] >> {rd_off, 3'b000};

    // Read FSM next state and result assembly.
    always_comb begin
        rd_st_d    = rd_st_q;
        rd_valid_d = 1'b0;
        rd_err_d   = rd_err_q;
        rd_data_d  = rd_data_q;
        rd_low_d   = rd_low_q;
        rd_nidx_d  = rd_nidx_q;
        rd_lob_d   = rd_lob_q;
        rd_size_d  = rd_size_q;
        rd_sgn_d   = rd_sgn_q;
        case (rd_st_q)
            ST_IDLE: begin
                if (rd_req) begin
                    if (rd_illegal) begin
                        // Out-of-range or oversize: answer at once, touch nothing.
                        rd_valid_d = 1'b1;
                        rd_err_d   = 1'b1;
                        rd_data_d  = '0;
                    end else if (rd_cross) begin
                        rd_st_d   = ST_BEAT2;
                        rd_low_d  = rd_shift;
                        rd_nidx_d = rd_idx + IDX_W'(1);
                        rd_lob_d  = (OFF_W+1)'(NB) - {1'b0, rd_off};
                        rd_size_d = rd_size;
                        rd_sgn_d  = rd_signed;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_err_d   = 1'b0;
                        rd_data_d  = extend(rd_shift, rd_size, rd_signed);
                    end
                end
            end
            ST_BEAT2: begin
                // High word is sampled now, so it reflects writes from the first beat.
                rd_st_d    = ST_IDLE;
                rd_valid_d = 1'b1;
                rd_err_d   = 1'b0;
                rd_data_d  = extend(rd_low_q | (mem_q[rd_nidx_q] << {rd_lob_q, 3'b000}),
                                    rd_size_q, rd_sgn_q);
            end
            default: rd_st_d = ST_IDLE;
        endcase
    end

    // Read port state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_low_q   <= '0;
            rd_nidx_q  <= '0;
            rd_lob_q   <= '0;
            rd_size_q  <= '0;
            rd_sgn_q   <= 1'b0;
        end else begin
            rd_st_q    <= rd_st_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            rd_low_q   <= rd_low_d;
            rd_nidx_q  <= rd_nidx_d;
            rd_lob_q   <= rd_lob_d;
            rd_size_q  <= rd_size_d;
            rd_sgn_q   <= rd_sgn_d;
        end
    end

    assign rd_ready = (rd_st_q == ST_IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_data_q;

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    st_e               wr_st_q, wr_st_d;
    logic              wr_err_q, wr_err_d;
    logic [NB-1:0]     wr_hi_en_q, wr_hi_en_d;
    logic [DATA_W-1:0] wr_hi_dat_q, wr_hi_dat_d;
    logic [IDX_W-1:0]  wr_nidx_q, wr_nidx_d;
    logic              wr_lo_we;
    logic              wr_hi_we;

    logic [OFF_W-1:0]    wr_off;
    logic [IDX_W-1:0]    wr_idx;
    logic [2*NB-1:0]     wr_en2;     // lane enables placed across word W and W+1
    logic [2*DATA_W-1:0] wr_dat2;
    logic [OFF_W:0]      wr_top;     // index of highest enabled lane, plus one
    logic [ADDR_W:0]     wr_end;
    logic                wr_illegal;

    assign wr_off     = wr_adrs[OFF_W-1:0];
    assign wr_idx     = wr_adrs[MEM_AW-1:OFF_W];
    assign wr_en2     = {{NB{1'b0}}, wr_byt_en} << wr_off;
    assign wr_dat2    = {{DATA_W{1'b0}}, wr_data} << {wr_off, 3'b000};
    assign wr_end     = {1'b0, wr_adrs} + (ADDR_W+1)'(wr_top);
    assign wr_illegal = (|wr_byt_en) && (wr_end > DEPTH_L);

    // Find the highest enabled lane; an empty enable never counts as out of range.
    always_comb begin
        wr_top = '0;
        for (int i = 0; i < NB; i++) begin
            if (wr_byt_en[i]) begin
                wr_top = (OFF_W+1)'(i + 1);
            end
        end
    end

    // Write FSM: commit the low word now, latch any spill-over for the next cycle.
    always_comb begin
        wr_st_d     = wr_st_q;
        wr_err_d    = 1'b0;
        wr_hi_en_d  = wr_hi_en_q;
        wr_hi_dat_d = wr_hi_dat_q;
        wr_nidx_d   = wr_nidx_q;
        wr_lo_we    = 1'b0;
        wr_hi_we    = 1'b0;
        case (wr_st_q)
            ST_IDLE: begin
                if (wr_req) begin
                    if (wr_illegal) begin
                        wr_err_d = 1'b1;
                    end else begin
                        wr_lo_we = 1'b1;
                        if (|wr_en2[2*NB-1:NB]) begin
                            wr_st_d     = ST_BEAT2;
                            wr_hi_en_d  = wr_en2[2*NB-1:NB];
                            wr_hi_dat_d = wr_dat2[2*DATA_W-1:DATA_W];
                            wr_nidx_d   = wr_idx + IDX_W'(1);
                        end
                    end
                end
            end
            ST_BEAT2: begin
                wr_st_d  = ST_IDLE;
                wr_hi_we = 1'b1;
            end
            default: wr_st_d = ST_IDLE;
        endcase
    end

    // Write port state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st_q     <= ST_IDLE;
            wr_err_q    <= 1'b0;
            wr_hi_en_q  <= '0;
            wr_hi_dat_q <= '0;
            wr_nidx_q   <= '0;
        end else begin
            wr_st_q     <= wr_st_d;
            wr_err_q    <= wr_err_d;
            wr_hi_en_q  <= wr_hi_en_d;
            wr_hi_dat_q <= wr_hi_dat_d;
            wr_nidx_q   <= wr_nidx_d;
        end
    end

    assign wr_ready = (wr_st_q == ST_IDLE);
    assign wr_err   = wr_err_q;

    // Storage update; the two beats are never active together because BEAT2 blocks acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr_lo_we && wr_en2[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_dat2[8*b +: 8];
                end
                if (wr_hi_we && wr_hi_en_q[b]) begin
                    mem_q[wr_nidx_q][8*b +: 8] <= wr_hi_dat_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_banked.sv
module tb_mem_banked;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_adrs;
    logic [1:0]    rd_size;
    logic          rd_signed;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          wr_req;
    logic [AW-1:0] wr_adrs;
    logic [3:0]    wr_byt_en;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_adrs   (rd_adrs),
        .rd_size   (rd_size),
        .rd_signed (rd_signed),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .wr_req    (wr_req),
        .wr_adrs   (wr_adrs),
        .wr_byt_en (wr_byt_en),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_err    (wr_err)
    );

    // is_wr: write vector; exp_lat: read latency, or for writes 1 when wr_ready must drop.
    typedef struct {
        bit          is_wr;
        logic [31:0] adrs;
        logic [1:0]  size;
        bit          sgn;
        logic [3:0]  en;
        logic [31:0] data;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] s, input bit g,
                           output logic [31:0] d, output logic e, output int lat);
        @(negedge clk);
        rd_req = 1'b1; rd_adrs = a; rd_size = s; rd_signed = g;
        @(posedge clk); #1;
        rd_req = 1'b0;
        lat = 1;
        while (!rd_valid && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rd_valid) lat = 99;
        d = rd_data;
        e = rd_err;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] en, input logic [31:0] dat,
                            output logic e, output int busy);
        @(negedge clk);
        wr_req = 1'b1; wr_adrs = a; wr_byt_en = en; wr_data = dat;
        @(posedge clk); #1;
        wr_req = 1'b0;
        e    = wr_err;
        busy = wr_ready ? 0 : 1;
        @(posedge clk); #1;
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;

    initial begin
        // is_wr adrs size sgn en data exp_data exp_err exp_lat
        vecs.push_back('{1'b1, 32'h010, 2'd0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h010, 2'd2, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h013, 2'd0, 1'b1, 4'h0, 32'h0,        32'hFFFFFFDE, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h013, 2'd0, 1'b0, 4'h0, 32'h0,        32'h000000DE, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h010, 2'd1, 1'b1, 4'h0, 32'h0,        32'hFFFFBEEF, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h011, 2'd1, 1'b0, 4'h0, 32'h0,        32'h0000ADBE, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h012, 2'd0, 1'b1, 4'h0, 32'h0,        32'hFFFFFFAD, 1'b0, 1});
        vecs.push_back('{1'b1, 32'h010, 2'd0, 1'b0, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h010, 2'd2, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{1'b1, 32'h01E, 2'd0, 1'b0, 4'hF, 32'h44332211, 32'h0,        1'b0, 1});
        vecs.push_back('{1'b0, 32'h01C, 2'd2, 1'b0, 4'h0, 32'h0,        32'h22110000, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h020, 2'd2, 1'b0, 4'h0, 32'h0,        32'h00004433, 1'b0, 1});
        vecs.push_back('{1'b0, 32'h01E, 2'd2, 1'b0, 4'h0, 32'h0,        32'h44332211, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h01F, 2'd1, 1'b1, 4'h0, 32'h0,        32'h00003322, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h3FE, 2'd2, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 32'h010, 2'd3, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 32'h3FF, 2'd0, 1'b0, 4'h3, 32'h0000AAAA, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 32'h3FC, 2'd2, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1});
        vecs.push_back('{1'b1, 32'h3FF, 2'd0, 1'b0, 4'h1, 32'h00000077, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h3FF, 2'd0, 1'b1, 4'h0, 32'h0,        32'h00000077, 1'b0, 1});
        vecs.push_back('{1'b1, 32'h3FE, 2'd0, 1'b0, 4'h3, 32'h00008081, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 32'h3FE, 2'd1, 1'b1, 4'h0, 32'h0,        32'hFFFF8081, 1'b0, 1});

        rst = 1'b1;
        rd_req = 1'b0; rd_adrs = '0; rd_size = '0; rd_signed = 1'b0;
        wr_req = 1'b0; wr_adrs = '0; wr_byt_en = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data",  rd_data,       32'd0);
        check("reset rd_err",   32'(rd_err),   32'd0);
        check("reset wr_err",   32'(wr_err),   32'd0);
        check("reset rd_ready", 32'(rd_ready), 32'd1);
        check("reset wr_ready", 32'(wr_ready), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].adrs, vecs[i].en, vecs[i].data, e, lat);
                check($sformatf("v%0d wr_err", i),  32'(e),   32'(vecs[i].exp_err));
                check($sformatf("v%0d wr_busy", i), 32'(lat), 32'(vecs[i].exp_lat));
            end else begin
                do_read(vecs[i].adrs, vecs[i].size, vecs[i].sgn, d, e, lat);
                check($sformatf("v%0d rd_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
                check($sformatf("v%0d rd_data", i), d,        vecs[i].exp_data);
                check($sformatf("v%0d rd_err", i),  32'(e),   32'(vecs[i].exp_err));
            end
        end

        // Same-cycle write and read of one word: read returns the old contents.
        @(negedge clk);
        wr_req = 1'b1; wr_adrs = 32'h10; wr_byt_en = 4'hF; wr_data = 32'h0;
        rd_req = 1'b1; rd_adrs = 32'h10; rd_size = 2'd2; rd_signed = 1'b0;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        check("rdw valid", 32'(rd_valid), 32'd1);
        check("rdw old",   rd_data,       32'hDEADBEEF);
        do_read(32'h10, 2'd2, 1'b0, d, e, lat);
        check("rdw new", d, 32'h0);

        // Both ports in their second beat together.
        @(negedge clk);
        wr_req = 1'b1; wr_adrs = 32'h2E; wr_byt_en = 4'hF; wr_data = 32'hA1B2C3D4;
        rd_req = 1'b1; rd_adrs = 32'h1E; rd_size = 2'd2; rd_signed = 1'b0;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        check("dual rd_ready beat2", 32'(rd_ready), 32'd0);
        check("dual wr_ready beat2", 32'(wr_ready), 32'd0);
        check("dual rd_valid beat1", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        check("dual rd_valid", 32'(rd_valid), 32'd1);
        check("dual rd_data",  rd_data,       32'h44332211);
        check("dual rd_ready", 32'(rd_ready), 32'd1);
        check("dual wr_ready", 32'(wr_ready), 32'd1);
        do_read(32'h2E, 2'd2, 1'b0, d, e, lat);
        check("dual wr result", d,        32'hA1B2C3D4);
        check("dual wr lat",    32'(lat), 32'd2);

        // Crossing read whose high word is written during its first beat.
        @(negedge clk);
        wr_req = 1'b1; wr_adrs = 32'h24; wr_byt_en = 4'hF; wr_data = 32'hCAFEF00D;
        rd_req = 1'b1; rd_adrs = 32'h22; rd_size = 2'd2; rd_signed = 1'b0;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        @(posedge clk); #1;
        check("beat2 sees write", rd_data, 32'hF00D0000);
        @(posedge clk); #1;
        check("rd_valid pulse", 32'(rd_valid), 32'd0);
        check("rd_data hold",   rd_data,       32'hF00D0000);

        // Reset while both ports are in their second beat.
        @(negedge clk);
        wr_req = 1'b1; wr_adrs = 32'h3E; wr_byt_en = 4'hF; wr_data = 32'h55667788;
        rd_req = 1'b1; rd_adrs = 32'h1E; rd_size = 2'd2; rd_signed = 1'b0;
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rst rd_ready", 32'(rd_ready), 32'd1);
        check("rst wr_ready", 32'(wr_ready), 32'd1);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst rd_data",  rd_data,       32'd0);
        @(posedge clk); #1;
        check("rst hold rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post rst rd_valid", 32'(rd_valid), 32'd0);
        do_read(32'h40, 2'd2, 1'b0, d, e, lat);
        check("no remainder write", d, 32'h0);
        do_read(32'h3C, 2'd2, 1'b0, d, e, lat);
        check("low part cleared", d, 32'h0);
        do_read(32'h1E, 2'd2, 1'b0, d, e, lat);
        check("cleared crossing", d,        32'h0);
        check("cleared cross lat", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
